// File: rtl/ps2_keyboard_rx_if.sv
// Key event handshake between the PS/2 receiver and its consumer.
//   key_code  : scan code at the FIFO head
//   key_break : head event is a key release
//   key_ext   : head event is an extended key
//   key_valid : an event is available
//   key_ready : consumer accepts the head event when key_valid is high
// master = receiver side, slave = consumer side.
interface ps2_keyboard_rx_if;
   logic [7:0] key_code;
   logic       key_break;
   logic       key_ext;
   logic       key_valid;
   logic       key_ready;

   modport master (
      output key_code, key_break, key_ext, key_valid,
      input  key_ready
   );

   modport slave (
      input  key_code, key_break, key_ext, key_valid,
      output key_ready
   );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the keyboard lines,
// checks 11-bit frames (start, odd parity, stop, inter-edge timeout),
// decodes make/break/extended events and queues them in a FWFT FIFO.
// Ports:
//   clk, rst      : system clock, asynchronous active-high reset
//   clk_kb        : PS/2 clock line (asynchronous, idle high)
//   data_kb       : PS/2 data line (asynchronous, idle high)
//   kb            : key event handshake (master side)
//   err_parity    : one-cycle pulse on parity failure
//   err_frame     : one-cycle pulse on bad start/stop bit or timeout
//   err_overflow  : one-cycle pulse when an event is dropped on a full FIFO
//   fifo_level    : number of stored events
module ps2_keyboard_rx #(
   parameter int FILTER_LEN = 4,
   parameter int TIMEOUT    = 100000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clk_kb,
   input  logic                            data_kb,
   ps2_keyboard_rx_if.master               kb,
   output logic                            err_parity,
   output logic                            err_frame,
   output logic                            err_overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

   localparam int FW = $clog2(FILTER_LEN);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // Stage p0/p1: two-flop synchronisers, idle-high reset value
   logic clk_p0, clk_p1, dat_p0, dat_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_p0 <= 1'b1;
         clk_p1 <= 1'b1;
         dat_p0 <= 1'b1;
         dat_p1 <= 1'b1;
      end else begin
         clk_p0 <= clk_kb;
         clk_p1 <= clk_p0;
         dat_p0 <= data_kb;
         dat_p1 <= dat_p0;
      end
   end

   // Stage p2: clock filter and falling-edge strobe
   logic          clk_filt_p2;
   logic [FW-1:0] flt_cnt;
   logic          vld_p2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_filt_p2 <= 1'b1;
         flt_cnt     <= '0;
         vld_p2      <= 1'b0;
      end else begin
         vld_p2 <= 1'b0;
         if (clk_p1 != clk_filt_p2) begin
            // FILTER_LEN-th consecutive disagreeing sample flips the level
            if (flt_cnt == FW'(FILTER_LEN - 1)) begin
               clk_filt_p2 <= clk_p1;
               flt_cnt     <= '0;
               vld_p2      <= clk_filt_p2;
            end else begin
               flt_cnt <= flt_cnt + FW'(1);
            end
         end else begin
            flt_cnt <= '0;
         end
      end
   end

   // Stage p3: frame FSM, timeout and make/break/extended decode
   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          par_bit;
   logic [TW-1:0] tcnt;
   logic          ext_pend, brk_pend;
   logic          vld_p3;
   logic [7:0]    code_p3;
   logic          brk_p3, ext_p3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift      <= '0;
         par_bit    <= 1'b0;
         tcnt       <= '0;
         ext_pend   <= 1'b0;
         brk_pend   <= 1'b0;
         vld_p3     <= 1'b0;
         code_p3    <= '0;
         brk_p3     <= 1'b0;
         ext_p3     <= 1'b0;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         vld_p3     <= 1'b0;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;

         if (vld_p2 || state == IDLE) tcnt <= '0;
         else                         tcnt <= tcnt + TW'(1);

         case (state)
            IDLE: if (vld_p2) begin
               if (!dat_p1) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end else begin
                  err_frame <= 1'b1;
                  ext_pend  <= 1'b0;
                  brk_pend  <= 1'b0;
               end
            end
            DATA: if (vld_p2) begin
               shift   <= {dat_p1, shift[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state <= PARITY;
            end
            PARITY: if (vld_p2) begin
               par_bit <= dat_p1;
               state   <= STOP;
            end
            STOP: if (vld_p2) begin
               state <= IDLE;
               if (!dat_p1) begin
                  err_frame <= 1'b1;
                  ext_pend  <= 1'b0;
                  brk_pend  <= 1'b0;
               end else if (!(^{shift, par_bit})) begin
                  // odd parity: total ones over data+parity must be odd
                  err_parity <= 1'b1;
                  ext_pend   <= 1'b0;
                  brk_pend   <= 1'b0;
               end else if (shift == 8'hE0) begin
                  ext_pend <= 1'b1;
               end else if (shift == 8'hF0) begin
                  brk_pend <= 1'b1;
               end else begin
                  vld_p3   <= 1'b1;
                  code_p3  <= shift;
                  brk_p3   <= brk_pend;
                  ext_p3   <= ext_pend;
                  ext_pend <= 1'b0;
                  brk_pend <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         // Inter-edge timeout abandons the partial frame
         if (state != IDLE && !vld_p2 && tcnt == TW'(TIMEOUT - 1)) begin
            state     <= IDLE;
            err_frame <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
         end
      end
   end

   // Stage p4: first-word-fall-through event FIFO
   logic [9:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic          full, pop, wr_en, valid;
   logic [9:0]    head;

   assign valid        = (level != '0);
   assign full         = (level == LW'(FIFO_DEPTH));
   assign pop          = valid && kb.key_ready;
   // A pop in the same cycle frees the slot the full FIFO needs
   assign wr_en        = vld_p3 && (!full || pop);
   assign err_overflow = vld_p3 && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= {code_p3, brk_p3, ext_p3};
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (wr_en && !pop)      level <= level + LW'(1);
         else if (!wr_en && pop) level <= level - LW'(1);
      end
   end

   assign head         = mem[rd_ptr];
   assign kb.key_code  = head[9:2];
   assign kb.key_break = head[1];
   assign kb.key_ext   = head[0];
   assign kb.key_valid = valid;
   assign fifo_level   = level;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: drives PS/2 frames bit by bit,
// queues the expected events as frames are sent and compares them as the
// receiver hands them out; error pulses are counted per step.
module tb_ps2_keyboard_rx;
   localparam int FILTER_LEN = 4;
   localparam int TIMEOUT    = 300;
   localparam int FIFO_DEPTH = 8;
   localparam int HP         = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       clk_kb, data_kb;
   logic       err_parity, err_frame, err_overflow;
   logic [3:0] fifo_level;

   ps2_keyboard_rx_if kb_if();

   ps2_keyboard_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clk_kb       (clk_kb),
      .data_kb      (data_kb),
      .kb           (kb_if),
      .err_parity   (err_parity),
      .err_frame    (err_frame),
      .err_overflow (err_overflow),
      .fifo_level   (fifo_level)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n_par = 0, n_frame = 0, n_ovf = 0, n_extra = 0;
   logic [9:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: compare every event the consumer accepts
   always @(negedge clk) begin
      if (!rst) begin
         if (err_parity)   n_par++;
         if (err_frame)    n_frame++;
         if (err_overflow) n_ovf++;
         if (kb_if.key_valid && kb_if.key_ready) begin
            if (exp_q.size() > 0)
               check("event", {22'd0, kb_if.key_code, kb_if.key_break, kb_if.key_ext},
                     {22'd0, exp_q.pop_front()});
            else
               n_extra++;
         end
      end
   end

   task automatic send_bit(input logic b, input logic glitch);
      data_kb = b;
      if (glitch) begin
         repeat (5) @(posedge clk);
         #1 clk_kb = 1'b0;
         repeat (FILTER_LEN - 1) @(posedge clk);
         #1 clk_kb = 1'b1;
         repeat (HP - 5 - (FILTER_LEN - 1)) @(posedge clk);
         #1;
      end else begin
         repeat (HP) @(posedge clk);
         #1;
      end
      clk_kb = 1'b0;
      repeat (HP) @(posedge clk);
      #1 clk_kb = 1'b1;
   endtask

   task automatic send_head(input logic [7:0] code, input logic bad_par, input logic glitch);
      send_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) send_bit(code[i], glitch);
      send_bit((~^code) ^ bad_par, glitch);
   endtask

   task automatic send_frame(input logic [7:0] code, input logic bad_par,
                             input logic stop_b, input logic glitch);
      send_head(code, bad_par, glitch);
      send_bit(stop_b, glitch);
      data_kb = 1'b1;
      repeat (30) @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      n_par = 0; n_frame = 0; n_ovf = 0; n_extra = 0;
   endtask

   initial begin
      rst = 1'b1; clk_kb = 1'b1; data_kb = 1'b1; kb_if.key_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_code",  {24'd0, kb_if.key_code}, 32'h00);
      check("rst_break", {31'd0, kb_if.key_break}, 32'd0);
      check("rst_ext",   {31'd0, kb_if.key_ext}, 32'd0);
      check("rst_valid", {31'd0, kb_if.key_valid}, 32'd0);
      check("rst_errs",  {29'd0, err_parity, err_frame, err_overflow}, 32'd0);
      check("rst_level", {28'd0, fifo_level}, 32'd0);

      // Single make code with exact output latency
      clear_counts();
      exp_q.push_back({8'h1C, 2'b00});
      send_head(8'h1C, 1'b0, 1'b0);
      data_kb = 1'b1;
      repeat (HP) @(posedge clk);
      #1 clk_kb = 1'b0;
      repeat (7) @(posedge clk);
      #1 check("lat_before", {31'd0, kb_if.key_valid}, 32'd0);
      @(posedge clk);
      #1 check("lat_valid", {31'd0, kb_if.key_valid}, 32'd1);
      repeat (HP - 8) @(posedge clk);
      #1 clk_kb = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("make_drained", exp_q.size(), 32'd0);
      check("make_extra",   n_extra, 32'd0);

      // Break and extended-break sequences
      clear_counts();
      exp_q.push_back({8'h1C, 2'b10});
      exp_q.push_back({8'h74, 2'b11});
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h74, 1'b0, 1'b1, 1'b0);
      check("brk_drained", exp_q.size(), 32'd0);
      check("brk_extra",   n_extra, 32'd0);
      check("brk_errs",    n_par + n_frame, 32'd0);

      // Parity error, stop error, then recovery
      clear_counts();
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
      check("par_count",   n_par, 32'd1);
      check("par_noframe", n_frame, 32'd0);
      check("par_noevent", n_extra, 32'd0);
      clear_counts();
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      check("stop_frame",  n_frame, 32'd1);
      check("stop_nopar",  n_par, 32'd0);
      check("stop_noevt",  n_extra, 32'd0);
      exp_q.push_back({8'h2A, 2'b00});
      send_frame(8'h2A, 1'b0, 1'b1, 1'b0);
      check("recov_drained", exp_q.size(), 32'd0);

      // Timeout mid-frame, then a good frame
      clear_counts();
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      data_kb = 1'b1;
      repeat (TIMEOUT + 10) @(posedge clk);
      #1;
      check("tmo_frame", n_frame, 32'd1);
      exp_q.push_back({8'h15, 2'b00});
      send_frame(8'h15, 1'b0, 1'b1, 1'b0);
      check("tmo_recov", exp_q.size(), 32'd0);
      check("tmo_extra", n_extra, 32'd0);

      // Reset mid-frame: silent recovery
      clear_counts();
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; data_kb = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      exp_q.push_back({8'h15, 2'b00});
      send_frame(8'h15, 1'b0, 1'b1, 1'b0);
      check("rstmid_recov", exp_q.size(), 32'd0);
      check("rstmid_noerr", n_frame + n_par, 32'd0);

      // Overflow with consumer stalled
      clear_counts();
      kb_if.key_ready = 1'b0;
      for (int i = 0; i <= FIFO_DEPTH; i++) begin
         if (i < FIFO_DEPTH) exp_q.push_back({8'h10 + 8'(i), 2'b00});
         send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
      end
      check("ovf_level", {28'd0, fifo_level}, FIFO_DEPTH);
      check("ovf_pulse", n_ovf, 32'd1);
      check("ovf_head",  {24'd0, kb_if.key_code}, 32'h10);

      // Push and pop in the same cycle while full
      exp_q.push_back({8'h19, 2'b00});
      send_head(8'h19, 1'b0, 1'b0);
      data_kb = 1'b1;
      repeat (HP) @(posedge clk);
      #1 clk_kb = 1'b0;
      repeat (7) @(posedge clk);
      #1 kb_if.key_ready = 1'b1;
      @(posedge clk);
      #1 kb_if.key_ready = 1'b0;
      repeat (HP - 8) @(posedge clk);
      #1 clk_kb = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("pp_level", {28'd0, fifo_level}, FIFO_DEPTH);
      check("pp_noovf", n_ovf, 32'd1);
      check("pp_head",  {24'd0, kb_if.key_code}, 32'h11);

      kb_if.key_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("drain_level", {28'd0, fifo_level}, 32'd0);
      check("drain_valid", {31'd0, kb_if.key_valid}, 32'd0);
      check("drain_queue", exp_q.size(), 32'd0);
      check("drain_extra", n_extra, 32'd0);

      // Sub-threshold clock glitches inside a frame
      clear_counts();
      exp_q.push_back({8'h1C, 2'b00});
      send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
      check("glitch_queue", exp_q.size(), 32'd0);
      check("glitch_errs",  n_par + n_frame + n_ovf, 32'd0);
      check("glitch_extra", n_extra, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Parametrised PS/2 keyboard receiver for the system clock domain. It oversamples the keyboard's clock and data lines, filters glitches, and checks each 11-bit frame for start, odd parity and stop bit, with an inter-edge timeout. Valid bytes are decoded into make/break events with extended-prefix tagging, and each event is buffered in a first-word-fall-through FIFO with a valid/ready handshake. It sits between the PS/2 connector pins and any keyboard consumer logic.

## Interface
- FILTER_LEN, 4: consecutive identical samples required before the filtered PS/2 clock changes level (≥2).
- TIMEOUT, 100000: system cycles allowed between filtered falling edges inside a frame.
- FIFO_DEPTH, 8: event FIFO entries; a power of 2, ≥2.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- clk_kb  in  1  PS/2 clock line, asynchronous to clk, idle high.
- data_kb  in  1  PS/2 data line, asynchronous to clk, idle high.
- key_code  out  8  scan code at the FIFO head.
- key_break  out  1  head event is a release (preceded by F0).
- key_ext  out  1  head event is extended (preceded by E0).
- key_valid  out  1  FIFO non-empty.
- key_ready  in  1  consumer accepts the head event when key_valid is also high.
- err_parity  out  1  one-cycle pulse: parity failure.
- err_frame  out  1  one-cycle pulse: bad start bit, bad stop bit, or timeout.
- err_overflow  out  1  one-cycle pulse: event dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  stored event count.

## Operation
- **Input conditioning**
  - Each line passes through a 2-flop synchroniser.
  - clk_kb then feeds a filter: the filtered level flips only after FILTER_LEN consecutive samples disagree with it.
  - A filtered 1→0 transition produces a one-cycle strobe. The synchronised data_kb is sampled on the strobe cycle.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP):
  - IDLE: strobe with data=0 → DATA, bit count cleared. Strobe with data=1 → err_frame, stay in IDLE.
  - DATA: shift in LSB first. After the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: always → IDLE. If data=0 → err_frame only. Otherwise, if the ones count over 8 data bits plus parity is even → err_parity. Otherwise the byte is accepted.
- **Timeout**
  - The cycle counter clears on every strobe and in IDLE.
  - In any non-IDLE state, reaching TIMEOUT → err_frame, go to IDLE, discard the partial byte.
- **Decoder**
  - Accepted E0 sets ext_pend. Accepted F0 sets brk_pend. Neither emits an event.
  - Any other accepted byte (including E1) emits {code, brk_pend, ext_pend}, then clears both flags.
  - Any err_frame or err_parity clears both flags.
- **FIFO**
  - An emitted event is written at the tail.
  - If full with no pop in the same cycle: the event is dropped and err_overflow pulses.
  - Full with a simultaneous pop: the write is accepted, no overflow, level unchanged.
  - Pop occurs when key_valid && key_ready. Output fields always reflect the head entry. Pointers wrap modulo FIFO_DEPTH.
- **Reset**
  - FSM returns to IDLE.
  - Synchronisers and filter reset to 1.
  - Counters, pending flags and FIFO are cleared.
  - Reset mid-frame discards the partial byte; no error pulse is generated.

## Timing
- Reset values: key_code=00, key_break=0, key_ext=0, key_valid=0, err_*=0, fifo_level=0.
- Input path: a stable clk_kb falling edge produces a strobe 2 (sync) + FILTER_LEN cycles later.
- Latency: on the stop-bit strobe in cycle N, the decoder registers the event in N+1. FIFO write in N+2 → key_valid high from N+2 if the FIFO was empty.
- Error pulses assert in cycle N+1 and last exactly one cycle.
- Pop: the head advances on the clock edge where key_valid && key_ready. The next entry is visible the following cycle; key_valid drops the same cycle if that was the last entry.
- fifo_level updates on the same edge as the push or pop.
- A clk_kb low pulse shorter than FILTER_LEN samples produces no strobe.

## Test plan
- Frame 0x1C (start 0, bits LSB first, parity 0, stop 1), key_ready=1 → one event: code 1C, break 0, ext 0; key_valid high exactly 2 cycles after the stop strobe.
- Sequence F0,1C then E0,F0,74 → two events only: {1C, break 1, ext 0} then {74, break 1, ext 1}.
- Frame 0x1C with parity 1 → single err_parity pulse, no event. Frame 0x1C with stop 0 → err_frame only. The following good frame 0x2A decodes correctly.
- Start bit plus 3 data bits, then clk_kb held high for TIMEOUT+10 cycles → one err_frame, FSM in IDLE. Next frame 0x15 decodes. Asserting rst mid-frame gives the same recovery with no error pulse.
- key_ready=0, send FIFO_DEPTH+1 distinct codes → fifo_level=FIFO_DEPTH and one err_overflow. Draining yields the first FIFO_DEPTH codes in order. A push plus pop in the same cycle while full produces no overflow.
- clk_kb low glitches of FILTER_LEN−1 cycles injected mid-frame → frame 0x1C still decodes, no errors.
